csa12_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 12-bit carry-select adder (`csa_12bit`) among NREQ requesters. It accepts operand pairs over valid/ready handshakes, drives the shared adder from registered operands, and captures the settled sum and carry-out into a response register. It returns the result with the requester ID on a single backpressured response channel. It sits between the requester ports and the adder instance, which is instantiated outside this block.

---
 rtl/csa12_share_arb_if.sv | 28 ++
 rtl/csa12_share_arb.sv | 181 ++++++++++++++++++
 tb/tb_csa12_share_arb.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa12_share_arb_if.sv
// Requester and response channels of the shared-adder arbiter.
// The master side is the requester/consumer; the slave side is the arbiter.
interface csa12_share_arb_if #(
   parameter int NREQ = 4,
   parameter int W    = 12
) ();
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              rsp_cout;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );
endinterface

// File: rtl/csa12_share_arb.sv
// Round-robin arbiter sharing one external 12-bit carry-select adder among NREQ
// requesters, with one registered, backpressured response channel.
module csa12_share_arb #(
   parameter int NREQ = 4,
   parameter int W    = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   csa12_share_arb_if.slave     bus,
   output logic [W-1:0]         add_a,
   output logic [W-1:0]         add_b,
   input  logic [W-1:0]         add_sum,
   input  logic                 add_cout,
   output logic                 busy,
   output logic [15:0]          done_cnt
);
   localparam int             IDW    = $clog2(NREQ);
   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t          state_q,     state_d;
   logic [IDW-1:0]  ptr_q,       ptr_d;
   logic [W-1:0]    op_a_q,      op_a_d;
   logic [W-1:0]    op_b_q,      op_b_d;
   logic [IDW-1:0]  cur_id_q,    cur_id_d;
   logic [W-1:0]    rsp_sum_q,   rsp_sum_d;
   logic            rsp_cout_q,  rsp_cout_d;
   logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            busy_q,      busy_d;
   logic [15:0]     done_cnt_q,  done_cnt_d;

   logic            gnt_found_s;
   logic [IDW-1:0]  gnt_idx_s;
   logic [IDW-1:0]  cand_s;
   logic [IDW:0]    wide_s;
   logic [IDW:0]    ptr_inc_s;
   logic            can_accept_s;
   logic            accept_s;
   logic [NREQ-1:0] req_ready_s;

   // Round-robin search: first valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = '0;
      cand_s      = '0;
      wide_s      = '0;
      for (int k = 0; k < NREQ; k++) begin
         wide_s = {1'b0, ptr_q} + (IDW+1)'(k);
         if (wide_s >= NREQ_W) begin
            wide_s = wide_s - NREQ_W;
         end else begin
            wide_s = wide_s;
         end
         cand_s = wide_s[IDW-1:0];
         if (!gnt_found_s && bus.req_valid[cand_s]) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = cand_s;
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // Accept window and the one-hot ready vector; reset forces all readies low.
   always_comb begin
      can_accept_s = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.rsp_ready));
      accept_s     = can_accept_s & gnt_found_s;
      if (accept_s) begin
         req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
      end else begin
         req_ready_s = '0;
      end
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      cur_id_d    = cur_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_id_d    = rsp_id_q;
      done_cnt_d  = done_cnt_q;
      ptr_inc_s   = {1'b0, gnt_idx_s} + {{IDW{1'b0}}, 1'b1};

      if (accept_s) begin
         op_a_d   = bus.req_a[gnt_idx_s*W +: W];
         op_b_d   = bus.req_b[gnt_idx_s*W +: W];
         cur_id_d = gnt_idx_s;
         if (ptr_inc_s >= NREQ_W) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_inc_s[IDW-1:0];
         end
      end else begin
         ptr_d = ptr_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // The adder has had the whole ISSUE cycle to settle on op_a/op_b.
            rsp_sum_d  = add_sum;
            rsp_cout_d = add_cout;
            rsp_id_d   = cur_id_q;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               if (done_cnt_q != 16'hFFFF) begin
                  done_cnt_d = done_cnt_q + 16'd1;
               end else begin
                  done_cnt_d = done_cnt_q;
               end
               state_d = accept_s ? ST_ISSUE : ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rsp_valid_d = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         cur_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         cur_id_q    <= cur_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign add_a         = op_a_q;
   assign add_b         = op_b_q;
   assign busy          = busy_q;
   assign done_cnt      = done_cnt_q;
endmodule

// File: tb/tb_csa12_share_arb.sv
// Self-checking bench for csa12_share_arb: directed scenarios plus random traffic
// compared each cycle against a transaction-level reference model.
module tb_csa12_share_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] add_a, add_b, add_sum;
   logic        add_cout;
   logic        busy;
   logic [15:0] done_cnt;

   always #5 clk = ~clk;

   csa12_share_arb_if #(.NREQ(4), .W(12)) bus ();

   csa12_share_arb #(.NREQ(4), .W(12)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .busy     (busy),
      .done_cnt (done_cnt)
   );

   // Behavioural stand-in for the external adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Driver state: requesters hold valid/operands until accepted.
   logic [3:0]  pend;
   logic [11:0] pa [4];
   logic [11:0] pb [4];
   logic        d_rrdy;
   logic        d_rst;

   // Reference model state.
   bit          m_issuing, m_hold;
   int          m_ptr, m_cur, m_id, m_done, hs_count;
   logic [11:0] m_opa, m_opb, m_sum;
   logic        m_cout;
   int          exp_id  [$];
   logic [12:0] exp_res [$];

   // Observation logs (DUT side).
   int          obs_log [$];
   logic [12:0] rsp_log [$];
   int          rsp_cyc [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_issuing = 1'b0; m_hold = 1'b0;
      m_ptr = 0; m_cur = 0; m_id = 0; m_done = 0; hs_count = 0;
      m_opa = '0; m_opb = '0; m_sum = '0; m_cout = 1'b0;
      exp_id.delete();
      exp_res.delete();
   endtask

   task automatic step();
      int         g;
      int         idx;
      logic [3:0] rdy_e;
      bit         can, acc, nh;
      @(negedge clk);
      rst           = d_rst;
      bus.req_valid = pend;
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*12 +: 12] = pa[i];
         bus.req_b[i*12 +: 12] = pb[i];
      end
      bus.rsp_ready = d_rrdy;
      #1;
      cyc++;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         idx = (m_ptr + k) % 4;
         if (g < 0 && pend[idx]) g = idx;
      end
      can   = !d_rst && !m_issuing && (!m_hold || d_rrdy);
      acc   = can && (g >= 0);
      rdy_e = acc ? (4'b0001 << g) : 4'b0000;

      chk("req_ready", 32'(bus.req_ready), 32'(rdy_e));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_hold));
      chk("rsp_sum",   32'(bus.rsp_sum),   32'(m_sum));
      chk("rsp_cout",  32'(bus.rsp_cout),  32'(m_cout));
      chk("rsp_id",    32'(bus.rsp_id),    32'(m_id));
      chk("busy",      32'(busy),          32'(m_issuing || m_hold));
      chk("done_cnt",  32'(done_cnt),      32'(m_done));
      chk("add_a",     32'(add_a),         32'(m_opa));
      chk("add_b",     32'(add_b),         32'(m_opb));

      for (int i = 0; i < 4; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i]) obs_log.push_back(i);
      end

      if (!d_rst && bus.rsp_valid && d_rrdy) begin
         hs_count++;
         rsp_log.push_back({bus.rsp_cout, bus.rsp_sum});
         rsp_cyc.push_back(cyc);
         if (exp_id.size() == 0) begin
            chk("sb_unexpected_rsp", 32'(bus.rsp_valid), 32'(0));
         end else begin
            chk("sb_id",  32'(bus.rsp_id), 32'(exp_id.pop_front()));
            chk("sb_res", 32'({bus.rsp_cout, bus.rsp_sum}), 32'(exp_res.pop_front()));
         end
      end

      if (d_rst) begin
         model_reset();
      end else begin
         nh = m_hold;
         if (m_hold && d_rrdy) begin
            nh = 1'b0;
            if (m_done < 65535) m_done++;
         end
         if (m_issuing) begin
            {m_cout, m_sum} = {1'b0, m_opa} + {1'b0, m_opb};
            m_id = m_cur;
            nh   = 1'b1;
         end
         m_issuing = acc;
         if (acc) begin
            m_opa = pa[g]; m_opb = pb[g]; m_cur = g;
            m_ptr = (g + 1) % 4;
            exp_id.push_back(g);
            exp_res.push_back({1'b0, pa[g]} + {1'b0, pb[g]});
            pend[g] = 1'b0;
         end
         m_hold = nh;
      end
   endtask

   initial begin
      int base;
      int n_acc;
      int budget;
      rst = 1'b1; d_rst = 1'b1; d_rrdy = 1'b0; pend = 4'b0000;
      for (int i = 0; i < 4; i++) begin pa[i] = '0; pb[i] = '0; end
      bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state with all requesters valid: nothing may be granted.
      pend = 4'b1111;
      step();
      pend = 4'b0000;
      d_rst = 1'b0;
      d_rrdy = 1'b1;
      step();

      // Single request from requester 2.
      pa[2] = 12'hFFF; pb[2] = 12'h001; pend = 4'b0100;
      obs_log.delete();
      step(); step(); step();
      chk("single_acc",   32'(obs_log.size()), 32'(1));
      chk("single_valid", 32'(bus.rsp_valid), 32'(1));
      chk("single_id",    32'(bus.rsp_id),    32'(2));
      chk("single_sum",   32'(bus.rsp_sum),   32'(12'h000));
      chk("single_cout",  32'(bus.rsp_cout),  32'(1));
      step();
      chk("single_cnt",   32'(done_cnt),      32'(1));

      // Contention from reset.
      for (int i = 0; i < 4; i++) begin pa[i] = 12'(32'h100 * i); pb[i] = 12'h023; end
      pend = 4'b1111; d_rst = 1'b1;
      step();
      d_rst = 1'b0;
      obs_log.delete(); rsp_log.delete(); rsp_cyc.delete();
      repeat (10) step();
      chk("cont_grants", 32'(obs_log.size()), 32'(4));
      chk("cont_rsps",   32'(rsp_log.size()), 32'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < obs_log.size()) chk("cont_order", 32'(obs_log[i]), 32'(i));
         if (i < rsp_log.size()) chk("cont_sum", 32'(rsp_log[i]), 32'(32'h100 * i + 32'h023));
         if (i > 0 && i < rsp_cyc.size()) chk("cont_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'(2));
      end

      // Fairness wrap: 3, then {1,3} -> 1 then 3, then {0,3} -> 0 first.
      obs_log.delete();
      pa[3] = 12'h3A5; pb[3] = 12'h05A; pend = 4'b1000;
      repeat (3) step();
      pa[1] = 12'h111; pb[1] = 12'h222; pend = pend | 4'b1010;
      repeat (6) step();
      pa[0] = 12'h800; pb[0] = 12'h800; pend = pend | 4'b1001;
      repeat (6) step();
      chk("fair_n", 32'(obs_log.size()), 32'(5));
      if (obs_log.size() == 5) begin
         chk("fair_0", 32'(obs_log[0]), 32'(3));
         chk("fair_1", 32'(obs_log[1]), 32'(1));
         chk("fair_2", 32'(obs_log[2]), 32'(3));
         chk("fair_3", 32'(obs_log[3]), 32'(0));
         chk("fair_4", 32'(obs_log[4]), 32'(3));
      end

      // Backpressure: response held 5 cycles with requester 0 pending.
      d_rrdy = 1'b0;
      pa[0] = 12'h0F0; pb[0] = 12'h00F; pend = 4'b0001;
      repeat (3) step();
      pa[0] = 12'h555; pb[0] = 12'hAAA; pend = 4'b0001;
      base = obs_log.size();
      repeat (5) step();
      chk("bp_no_acc", 32'(obs_log.size()), 32'(base));
      chk("bp_hold",   32'({bus.rsp_cout, bus.rsp_sum}), 32'(13'h0FF));
      d_rrdy = 1'b1;
      step();
      chk("bp_acc", 32'(obs_log.size()), 32'(base + 1));
      repeat (3) step();

      // Reset during ISSUE discards the operation.
      pa[1] = 12'h7FF; pb[1] = 12'h801; pend = 4'b0010;
      step();
      d_rst = 1'b1;
      step();
      d_rst = 1'b0;
      step();
      chk("rst_valid", 32'(bus.rsp_valid), 32'(0));
      chk("rst_sum",   32'(bus.rsp_sum),   32'(0));
      chk("rst_busy",  32'(busy),          32'(0));
      chk("rst_cnt",   32'(done_cnt),      32'(0));
      chk("rst_adda",  32'(add_a),         32'(0));
      rsp_log.delete();
      pend = 4'b0010;
      repeat (4) step();
      chk("rst_after_n",   32'(rsp_log.size()), 32'(1));
      if (rsp_log.size() == 1) chk("rst_after_res", 32'(rsp_log[0]), 32'(13'h1000));

      // Random traffic.
      base = obs_log.size();
      n_acc = 0;
      budget = 0;
      while (n_acc < 10000 && budget < 60000) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pa[i] = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
               pb[i] = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
               pend[i] = 1'b1;
            end
         end
         d_rrdy = ($urandom_range(0, 3) != 0);
         step();
         budget++;
         n_acc = obs_log.size() - base;
      end
      chk("rand_budget", 32'(n_acc >= 10000), 32'(1));
      pend = 4'b0000; d_rrdy = 1'b1;
      repeat (6) step();
      chk("rand_lost",  32'(exp_id.size()), 32'(0));
      chk("rand_done",  32'(done_cnt),      32'(hs_count));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
